// File: rtl/gf22mul_scl_pipe_pkg.sv
// Shared constants and types for the masked GF(2^2) multiplier pipeline.
// Lane width, scaling-mode encodings and the per-lane partial-product bundle.
package gf22mul_scl_pipe_pkg;

    localparam int   GF22_W     = 2;
    localparam logic SCL_SCALED = 1'b1;
    localparam logic SCL_PLAIN  = 1'b0;

    typedef logic [GF22_W-1:0] gf22_t;

    typedef struct packed {
        gf22_t pp00;
        gf22_t pp01;
        gf22_t pp10;
        gf22_t pp11;
    } pp_t;

endpackage

// File: rtl/gf22_core.sv
// Factored normal-basis GF(2^2) multiplier core, optionally scaled.
// The NAND complements cancel pairwise, so the output is bilinear in x and y.
module gf22_core
    import gf22mul_scl_pipe_pkg::*;
(
    input  logic [GF22_W-1:0] x,
    input  logic [GF22_W-1:0] y,
    input  logic              m,
    output logic [GF22_W-1:0] z
);

    logic s;
    logic f;
    logic p2;
    logic p1;
    logic p0;

    assign s  = x[1] ^ x[0];
    assign f  = y[1] ^ y[0];
    assign p2 = ~(f & s);
    assign p1 = ~(x[1] & y[1]);
    assign p0 = ~(x[0] & y[0]);

    always_comb begin
        z = {p2 ^ p1, p2 ^ p0};
        case (m)
            SCL_SCALED: z = {p2 ^ p0, p1 ^ p0};
            SCL_PLAIN:  z = {p2 ^ p1, p2 ^ p0};
        endcase
    end

endmodule

// File: rtl/gf22mul_scl_pipe.sv
// Pipelined multi-lane 2-share masked GF(2^2) multiplier with optional scaling.
// S1 registers the refreshed cross-share products; compression reads registers only.
module gf22mul_scl_pipe
    import gf22mul_scl_pipe_pkg::*;
#(
    parameter int LANES    = 4,
    parameter bit PIPE_OUT = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    scl,
    input  logic [GF22_W*LANES-1:0] a_s0,
    input  logic [GF22_W*LANES-1:0] a_s1,
    input  logic [GF22_W*LANES-1:0] b_s0,
    input  logic [GF22_W*LANES-1:0] b_s1,
    input  logic [GF22_W*LANES-1:0] rnd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [GF22_W*LANES-1:0] q_s0,
    output logic [GF22_W*LANES-1:0] q_s1
);

    pp_t [LANES-1:0]         pp_c;
    pp_t [LANES-1:0]         pp_r;
    logic [GF22_W*LANES-1:0] q0_c;
    logic [GF22_W*LANES-1:0] q1_c;
    logic                    s1_v;
    logic                    down_ready;
    logic                    in_fire;

    assign in_ready = ~s1_v | down_ready;
    assign in_fire  = in_valid & in_ready & ~flush;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gf22_t c00;
        gf22_t c01;
        gf22_t c10;
        gf22_t c11;
        gf22_t r;

        assign r = rnd[GF22_W*k +: GF22_W];

        gf22_core u_c00 (.x(a_s0[GF22_W*k +: GF22_W]), .y(b_s0[GF22_W*k +: GF22_W]), .m(scl), .z(c00));
        gf22_core u_c01 (.x(a_s0[GF22_W*k +: GF22_W]), .y(b_s1[GF22_W*k +: GF22_W]), .m(scl), .z(c01));
        gf22_core u_c10 (.x(a_s1[GF22_W*k +: GF22_W]), .y(b_s0[GF22_W*k +: GF22_W]), .m(scl), .z(c10));
        gf22_core u_c11 (.x(a_s1[GF22_W*k +: GF22_W]), .y(b_s1[GF22_W*k +: GF22_W]), .m(scl), .z(c11));

        assign pp_c[k] = {c00, c01 ^ r, c10 ^ r, c11};

        // Share domains meet only here, after the S1 glitch barrier.
        assign q0_c[GF22_W*k +: GF22_W] = pp_r[k].pp00 ^ pp_r[k].pp01;
        assign q1_c[GF22_W*k +: GF22_W] = pp_r[k].pp11 ^ pp_r[k].pp10;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            s1_v <= 1'b0;
            pp_r <= '0;
        end else begin
            if (flush) begin
                s1_v <= 1'b0;
            end else if (in_ready) begin
                s1_v <= in_valid;
            end
            if (in_fire) begin
                pp_r <= pp_c;
            end
        end
    end

    if (PIPE_OUT) begin : g_out
        logic                    s2_v;
        logic [GF22_W*LANES-1:0] q0_r;
        logic [GF22_W*LANES-1:0] q1_r;

        assign down_ready = ~s2_v | out_ready;

        always_ff @(posedge CLK or negedge RSTn) begin
            if (!RSTn) begin
                s2_v <= 1'b0;
                q0_r <= '0;
                q1_r <= '0;
            end else begin
                if (flush) begin
                    s2_v <= 1'b0;
                end else if (down_ready) begin
                    s2_v <= s1_v;
                end
                if (down_ready && s1_v) begin
                    q0_r <= q0_c;
                    q1_r <= q1_c;
                end
            end
        end

        assign out_valid = s2_v;
        assign q_s0      = q0_r;
        assign q_s1      = q1_r;
    end else begin : g_comb
        assign down_ready = out_ready;
        assign out_valid  = s1_v;
        assign q_s0       = q0_c;
        assign q_s1       = q1_c;
    end

endmodule

// File: tb/tb_gf22mul_scl_pipe.sv
// Self-checking bench for gf22mul_scl_pipe: directed vectors plus an unmasked
// GF(2^2) reference model and an in-order scoreboard checked every cycle.
module tb_gf22mul_scl_pipe;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic       scl;
    logic [7:0] a_s0, a_s1, b_s0, b_s1, rnd;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] q_s0, q_s1;

    int nCompare = 0;
    int nMiss    = 0;
    int outFires = 0;
    int lastWaits;

    logic [7:0] expQ[$];
    logic       stallPrev = 1'b0;
    logic [7:0] q0Prev, q1Prev;

    gf22mul_scl_pipe #(.LANES(4), .PIPE_OUT(1'b1)) dut (
        .CLK(CLK), .RSTn(RSTn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .scl(scl),
        .a_s0(a_s0), .a_s1(a_s1), .b_s0(b_s0), .b_s1(b_s1), .rnd(rnd),
        .out_valid(out_valid), .out_ready(out_ready),
        .q_s0(q_s0), .q_s1(q_s1)
    );

    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Unmasked reference: plain product (h,l); the scaled result is the linear map (l, h^l).
    function automatic logic [1:0] gfMul(input logic [1:0] x, input logic [1:0] y, input logic m);
        logic fs, h, l;
        fs = (x[1] ^ x[0]) & (y[1] ^ y[0]);
        h  = fs ^ (x[1] & y[1]);
        l  = fs ^ (x[0] & y[0]);
        return m ? {l, h ^ l} : {h, l};
    endfunction

    function automatic logic [7:0] modelVec(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] b0, input logic [7:0] b1,
                                            input logic m);
        logic [7:0] a, b, res;
        a = a0 ^ a1;
        b = b0 ^ b1;
        res = '0;
        for (int k = 0; k < 4; k++)
            res[2*k +: 2] = gfMul(a[2*k +: 2], b[2*k +: 2], m);
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompare++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard and stall-stability checks, sampled on the falling edge.
    always @(negedge CLK) begin
        logic [7:0] e;
        if (!RSTn) begin
            expQ.delete();
            stallPrev = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_q0", q_s0, q0Prev);
                checkOutput("stall_q1", q_s1, q1Prev);
            end
            if (out_valid && out_ready) begin
                outFires++;
                if (expQ.size() == 0) begin
                    checkOutput("spurious_out", out_valid, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("product", q_s0 ^ q_s1, e);
                end
            end
            if (in_valid && in_ready && !flush)
                expQ.push_back(modelVec(a_s0, a_s1, b_s0, b_s1, scl));
            if (flush)
                expQ.delete();
            stallPrev = out_valid && !out_ready && !flush;
            q0Prev = q_s0;
            q1Prev = q_s1;
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        a_s0 = '0; a_s1 = '0; b_s0 = '0; b_s1 = '0; rnd = '0;
    endtask

    // Present one transaction and hold it until accepted; returns just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] b0,
                                 input logic [7:0] b1, input logic [7:0] r, input logic m);
        logic acc;
        int waits;
        a_s0 = a0; a_s1 = a1; b_s0 = b0; b_s1 = b1; rnd = r; scl = m;
        in_valid = 1'b1;
        acc = 1'b0;
        waits = 0;
        while (!acc && waits < 50) begin
            @(negedge CLK);
            acc = in_ready;
            @(posedge CLK);
            #1;
            if (!acc) waits++;
        end
        if (!acc) checkOutput("accept_timeout", in_ready, 1);
        lastWaits = waits;
    endtask

    task automatic waitOut(input string name, input int expLat, input logic [1:0] expLane0);
        int lat;
        logic found;
        found = 1'b0;
        lat = 0;
        while (!found && lat < 20) begin
            lat++;
            @(negedge CLK);
            #1;
            found = out_valid;
        end
        if (!found) lat = 99;
        checkOutput({name, "_latency"}, lat, expLat);
        if (found) checkOutput({name, "_lane0"}, (q_s0 ^ q_s1) & 8'h03, {6'b0, expLane0});
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] v1a0, v1a1, v1b0, v1b1, v1r;
        logic [7:0] v2a0, v2a1, v2b0, v2b1, v2r;
        logic [7:0] x0, x1, y0, y1, rr, aU, bU;
        logic [7:0] q0h, q1h;
        int waitsTotal, firesBefore, nSweep;
        logic anyOut;

        RSTn = 1'b0; flush = 1'b0; scl = 1'b0; out_ready = 1'b1;
        idle();
        #2;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_q_s0", q_s0, 0);
        checkOutput("reset_q_s1", q_s1, 0);

        checkOutput("model_plain_10x11", gfMul(2'b10, 2'b11, 1'b0), 2'b10);
        checkOutput("model_scaled_10x11", gfMul(2'b10, 2'b11, 1'b1), 2'b01);
        checkOutput("model_plain_01x01", gfMul(2'b01, 2'b01, 1'b0), 2'b10);
        checkOutput("model_scaled_01x01", gfMul(2'b01, 2'b01, 1'b1), 2'b01);
        checkOutput("model_zero", gfMul(2'b00, 2'b11, 1'b1), 2'b00);

        @(posedge CLK); @(posedge CLK); #3;
        RSTn = 1'b1;
        @(posedge CLK); #1;
        checkOutput("post_reset_in_ready", in_ready, 1);

        $display("[TB] unmasked single-lane vectors");
        applyStimulus(8'b10, 8'b00, 8'b11, 8'b00, 8'b00, 1'b0);
        idle();
        waitOut("unmasked_plain", 2, 2'b10);
        applyStimulus(8'b10, 8'b00, 8'b11, 8'b00, 8'b00, 1'b1);
        idle();
        waitOut("unmasked_scaled", 2, 2'b01);

        $display("[TB] masked vector");
        applyStimulus(8'b01, 8'b11, 8'b10, 8'b01, 8'b11, 1'b0);
        idle();
        waitOut("masked", 2, 2'b10);

        $display("[TB] streaming sweep");
        waitsTotal = 0;
        nSweep = 0;
        firesBefore = outFires;
        for (int m = 0; m < 2; m++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++)
                    for (int rep = 0; rep < 4; rep++) begin
                        aU = {6'($urandom_range(63, 0)), 2'(a)};
                        bU = {6'($urandom_range(63, 0)), 2'(b)};
                        x0 = 8'($urandom_range(255, 0));
                        y0 = 8'($urandom_range(255, 0));
                        rr = 8'($urandom_range(255, 0));
                        if (rep == 0) begin
                            x0 = '0; y0 = '0; rr = '0;
                        end
                        x1 = x0 ^ aU;
                        y1 = y0 ^ bU;
                        applyStimulus(x0, x1, y0, y1, rr, 1'(m));
                        waitsTotal += lastWaits;
                        nSweep++;
                    end
        idle();
        @(negedge CLK); @(negedge CLK); #1;
        checkOutput("sweep_input_stalls", waitsTotal, 0);
        checkOutput("sweep_outputs_no_bubble", outFires - firesBefore, nSweep);
        @(posedge CLK); #1;

        $display("[TB] back-pressure");
        v1a0 = 8'h5A; v1a1 = 8'h33; v1b0 = 8'hC6; v1b1 = 8'h0F; v1r = 8'h96;
        v2a0 = 8'h21; v2a1 = 8'hE4; v2b0 = 8'h7B; v2b1 = 8'h18; v2r = 8'h4D;
        out_ready = 1'b0;
        scl = 1'b1;
        a_s0 = v1a0; a_s1 = v1a1; b_s0 = v1b0; b_s1 = v1b1; rnd = v1r; in_valid = 1'b1;
        @(posedge CLK); #1;
        a_s0 = v2a0; a_s1 = v2a1; b_s0 = v2b0; b_s1 = v2b1; rnd = v2r;
        @(posedge CLK); #1;
        checkOutput("bp_in_ready_low", in_ready, 0);
        checkOutput("bp_out_valid", out_valid, 1);
        a_s0 = 8'h9C; a_s1 = 8'h42; b_s0 = 8'hD1; b_s1 = 8'h6E; rnd = 8'hA5;
        q0h = q_s0;
        q1h = q_s1;
        checkOutput("bp_head", q_s0 ^ q_s1, modelVec(v1a0, v1a1, v1b0, v1b1, 1'b1));
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            checkOutput("bp_hold_in_ready", in_ready, 0);
            checkOutput("bp_hold_valid", out_valid, 1);
            checkOutput("bp_hold_q0", q_s0, q0h);
            checkOutput("bp_hold_q1", q_s1, q1h);
        end
        out_ready = 1'b1;
        @(posedge CLK); #1;
        idle();
        checkOutput("bp_order_second", q_s0 ^ q_s1, modelVec(v2a0, v2a1, v2b0, v2b1, 1'b1));
        @(posedge CLK); #1;
        checkOutput("bp_order_third", q_s0 ^ q_s1, modelVec(8'h9C, 8'h42, 8'hD1, 8'h6E, 1'b1));
        @(posedge CLK); #1;
        checkOutput("bp_drained", out_valid, 0);

        $display("[TB] flush with both stages full");
        out_ready = 1'b0;
        scl = 1'b0;
        a_s0 = v1a0; a_s1 = v1a1; b_s0 = v1b0; b_s1 = v1b1; rnd = v1r; in_valid = 1'b1;
        @(posedge CLK); #1;
        a_s0 = v2a0; a_s1 = v2a1; b_s0 = v2b0; b_s1 = v2b1; rnd = v2r;
        @(posedge CLK); #1;
        a_s0 = 8'h11; a_s1 = 8'h22; b_s0 = 8'h33; b_s1 = 8'h44; rnd = 8'h55;
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        idle();
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_s1_v", dut.s1_v, 0);
        checkOutput("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        anyOut = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK); #1;
            anyOut = anyOut | out_valid;
        end
        checkOutput("flush_nothing_emerges", anyOut, 0);
        @(posedge CLK); #1;

        $display("[TB] asynchronous reset mid-stream");
        for (int i = 0; i < 6; i++)
            applyStimulus(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                          8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                          8'($urandom_range(255, 0)), 1'(i % 2));
        #2;
        checkOutput("rst_pre_out_valid", out_valid, 1);
        RSTn = 1'b0;
        #1;
        idle();
        checkOutput("rst_async_out_valid", out_valid, 0);
        checkOutput("rst_async_q_s0", q_s0, 0);
        checkOutput("rst_async_q_s1", q_s1, 0);
        @(posedge CLK); #3;
        RSTn = 1'b1;
        @(posedge CLK); #1;
        checkOutput("rst_release_out_valid", out_valid, 0);
        applyStimulus(8'b01, 8'b11, 8'b10, 8'b01, 8'b11, 1'b0);
        idle();
        waitOut("after_reset", 2, 2'b10);

        repeat (3) @(posedge CLK);
        #1;
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nCompare, nMiss);
        $finish;
    end

endmodule
